// File: rtl/fifo_kband_out_sc.sv
// ---------------------------------------------------------------------------
// fifo_kband_out_sc
//
// Single-clock width-down-converting FIFO for the K-band output path.
// Wide result words from the systolic array (IN_WIDTH bits) are stored
// whole and handed back to the host/DMA side as IN_WIDTH/RATIO-bit
// slices, least-significant slice first.
//
// Parameters:
//   IN_WIDTH   - write word width, multiple of RATIO
//   RATIO      - slices per word, power of two 1..16
//   DEPTH      - capacity in whole words, power of two >= 2
//   AF_THRESH  - almost_full asserts when wrusedw >= AF_THRESH
//   SHOW_AHEAD - 1: q shows the head slice combinationally while !rdempty
//                0: q is registered and loads on an accepted read
//
// Ports:
//   clk         - single clock for all logic
//   reset       - synchronous active-high reset, clears everything
//   data        - write word
//   wrreq       - write request, accepted when !wrfull
//   rdreq       - read request (one slice), accepted when !rdempty
//   q           - read slice
//   wrusedw     - words occupied (a partially read word still counts)
//   rdusedw     - slices remaining
//   rdempty     - no slices available
//   wrfull      - wrusedw == DEPTH
//   almost_full - wrusedw >= AF_THRESH
//   overflow    - sticky, write attempted while full
//   underflow   - sticky, read attempted while empty
// ---------------------------------------------------------------------------
module fifo_kband_out_sc #(
    parameter int IN_WIDTH   = 512,
    parameter int RATIO      = 4,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6,
    parameter int SHOW_AHEAD = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [IN_WIDTH-1:0]                 data,
    input  logic                                wrreq,
    input  logic                                rdreq,
    output logic [IN_WIDTH/RATIO-1:0]           q,
    output logic [$clog2(DEPTH+1)-1:0]          wrusedw,
    output logic [$clog2(DEPTH*RATIO+1)-1:0]    rdusedw,
    output logic                                rdempty,
    output logic                                wrfull,
    output logic                                almost_full,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int W   = IN_WIDTH / RATIO;
    localparam int PW  = $clog2(DEPTH);
    localparam int SW  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int WUW = $clog2(DEPTH + 1);
    localparam int RUW = $clog2(DEPTH * RATIO + 1);

    localparam logic [WUW-1:0] DEPTH_W     = WUW'(DEPTH);
    localparam logic [WUW-1:0] AF_W        = WUW'(AF_THRESH);
    localparam logic [RUW-1:0] RATIO_R     = RUW'(RATIO);
    localparam logic [SW-1:0]  LAST_SLICE  = SW'(RATIO - 1);

    // Storage and pointers. Both pointers wrap naturally because DEPTH is
    // a power of two.
    logic [IN_WIDTH-1:0] mem_q [DEPTH];
    logic [IN_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]       slice_q, slice_d;

    logic [WUW-1:0]      wrusedw_q, wrusedw_d;
    logic [RUW-1:0]      rdusedw_q, rdusedw_d;
    logic                rdempty_q, rdempty_d;
    logic                wrfull_q, wrfull_d;
    logic                almost_full_q, almost_full_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                wr_accept;
    logic                rd_accept;
    logic                word_done;
    logic [IN_WIDTH-1:0] head_word;
    logic [W-1:0]        head_slice;

    // Acceptance is decided on the registered status flags only, so a word
    // freed this cycle cannot be refilled until the next one.
    assign wr_accept = wrreq && !wrfull_q;
    assign rd_accept = rdreq && !rdempty_q;
    assign word_done = rd_accept && (slice_q == LAST_SLICE);

    // Head slice: current read word shifted down by the slice counter.
    assign head_word  = mem_q[rd_ptr_q];
    assign head_slice = head_word[int'(slice_q)*W +: W];

    // Next-state for storage, pointers and slice counter.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        slice_d  = slice_q;

        if (wr_accept) begin
            mem_d[wr_ptr_q] = data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end

        if (rd_accept) begin
            if (slice_q == LAST_SLICE) begin
                slice_d  = '0;
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                slice_d  = slice_q + SW'(1);
            end
        end
    end

    // Next-state for occupancy counters and status flags. The flags are
    // derived from the next counter values so they are always consistent
    // with the counters visible in the same cycle.
    always_comb begin
        wrusedw_d     = wrusedw_q + WUW'(wr_accept) - WUW'(word_done);
        rdusedw_d     = rdusedw_q + (wr_accept ? RATIO_R : '0) - RUW'(rd_accept);
        rdempty_d     = (rdusedw_d == '0);
        wrfull_d      = (wrusedw_d == DEPTH_W);
        almost_full_d = (wrusedw_d >= AF_W);
        overflow_d    = overflow_q  || (wrreq && wrfull_q);
        underflow_d   = underflow_q || (rdreq && rdempty_q);
    end

    // State register. Reset wipes the array too, so a show-ahead q reads
    // zero immediately after reset rather than stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            slice_q       <= '0;
            wrusedw_q     <= '0;
            rdusedw_q     <= '0;
            rdempty_q     <= 1'b1;
            wrfull_q      <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            slice_q       <= slice_d;
            wrusedw_q     <= wrusedw_d;
            rdusedw_q     <= rdusedw_d;
            rdempty_q     <= rdempty_d;
            wrfull_q      <= wrfull_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // Output slice path: either a direct view of the head slice, or a
    // register that captures the slice being consumed and otherwise holds.
    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            assign q = head_slice;
        end else begin : g_registered
            logic [W-1:0] q_q, q_d;

            always_comb begin
                q_d = q_q;
                if (rd_accept) begin
                    q_d = head_slice;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    q_q <= '0;
                end else begin
                    q_q <= q_d;
                end
            end

            assign q = q_q;
        end
    endgenerate

    assign wrusedw     = wrusedw_q;
    assign rdusedw     = rdusedw_q;
    assign rdempty     = rdempty_q;
    assign wrfull      = wrfull_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_kband_out_sc.sv
// ---------------------------------------------------------------------------
// tb_fifo_kband_out_sc
//
// Directed bench for fifo_kband_out_sc. One instance uses the default
// 512->128, depth-8, registered-q configuration; a second instance uses
// 64->32 with show-ahead. A queue of expected slices is filled whenever a
// write should be accepted and drained whenever a read should be accepted;
// counters and flags are derived from the queue length.
// ---------------------------------------------------------------------------
module tb_fifo_kband_out_sc;

    logic         clk;
    logic         reset;

    // Default configuration instance
    logic [511:0] data;
    logic         wrreq;
    logic         rdreq;
    logic [127:0] q;
    logic [3:0]   wrusedw;
    logic [5:0]   rdusedw;
    logic         rdempty, wrfull, almost_full, overflow, underflow;

    // Show-ahead, 64->32 instance
    logic [63:0]  sa_data;
    logic         sa_wrreq;
    logic         sa_rdreq;
    logic [31:0]  sa_q;
    logic [3:0]   sa_wrusedw;
    logic [4:0]   sa_rdusedw;
    logic         sa_rdempty, sa_wrfull, sa_almost_full, sa_overflow, sa_underflow;

    int checks;
    int errors;

    // Model state
    logic [127:0] sb[$];
    logic [127:0] exp_q;
    logic         exp_over;
    logic         exp_under;

    fifo_kband_out_sc dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .wrreq       (wrreq),
        .rdreq       (rdreq),
        .q           (q),
        .wrusedw     (wrusedw),
        .rdusedw     (rdusedw),
        .rdempty     (rdempty),
        .wrfull      (wrfull),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    fifo_kband_out_sc #(
        .IN_WIDTH   (64),
        .RATIO      (2),
        .DEPTH      (8),
        .AF_THRESH  (6),
        .SHOW_AHEAD (1)
    ) dut_sa (
        .clk         (clk),
        .reset       (reset),
        .data        (sa_data),
        .wrreq       (sa_wrreq),
        .rdreq       (sa_rdreq),
        .q           (sa_q),
        .wrusedw     (sa_wrusedw),
        .rdusedw     (sa_rdusedw),
        .rdempty     (sa_rdempty),
        .wrfull      (sa_wrfull),
        .almost_full (sa_almost_full),
        .overflow    (sa_overflow),
        .underflow   (sa_underflow)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Wait for the active edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every output of the default instance against the model
    task automatic checkOutput(input string tag);
        int n;
        int words;
        n     = sb.size();
        words = (n + 3) / 4;
        chk({tag, ".wrusedw"},     128'(wrusedw),     128'(words));
        chk({tag, ".rdusedw"},     128'(rdusedw),     128'(n));
        chk({tag, ".rdempty"},     128'(rdempty),     128'(n == 0));
        chk({tag, ".wrfull"},      128'(wrfull),      128'(words == 8));
        chk({tag, ".almost_full"}, 128'(almost_full), 128'(words >= 6));
        chk({tag, ".overflow"},    128'(overflow),    128'(exp_over));
        chk({tag, ".underflow"},   128'(underflow),   128'(exp_under));
        chk({tag, ".q"},           q,                 exp_q);
    endtask

    // One clock of stimulus on the default instance, updating the model
    task automatic applyStimulus(input logic wr, input logic [511:0] d, input logic rd);
        logic full_before;
        logic empty_before;
        full_before  = (((sb.size() + 3) / 4) == 8);
        empty_before = (sb.size() == 0);
        wrreq = wr;
        data  = d;
        rdreq = rd;
        tick();
        wrreq = 1'b0;
        rdreq = 1'b0;
        if (rd && !empty_before) exp_q = sb.pop_front();
        if (rd && empty_before)  exp_under = 1'b1;
        if (wr && !full_before) begin
            for (int k = 0; k < 4; k++) sb.push_back(d[k*128 +: 128]);
        end
        if (wr && full_before) exp_over = 1'b1;
    endtask

    // Reset with both requests active to show they are ignored
    task automatic doReset();
        reset = 1'b1;
        wrreq = 1'b1;
        rdreq = 1'b1;
        data  = {4{128'hDEAD}};
        tick();
        reset = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        sb.delete();
        exp_q     = '0;
        exp_over  = 1'b0;
        exp_under = 1'b0;
    endtask

    function automatic logic [511:0] make_word(input int n);
        logic [511:0] w;
        for (int k = 0; k < 4; k++) begin
            w[k*128 +: 128] = {32'hC0DE0000 | 32'(n), 32'h0, 64'(k) + 64'h100};
        end
        return w;
    endfunction

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        data      = '0;
        wrreq     = 1'b0;
        rdreq     = 1'b0;
        sa_data   = '0;
        sa_wrreq  = 1'b0;
        sa_rdreq  = 1'b0;
        exp_q     = '0;
        exp_over  = 1'b0;
        exp_under = 1'b0;

        $display("[TB] reset state");
        doReset();
        checkOutput("reset");

        $display("[TB] read while empty");
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("underflow");

        doReset();
        checkOutput("reset2");

        $display("[TB] single word, slices 1..4");
        applyStimulus(1'b1, {128'd4, 128'd3, 128'd2, 128'd1}, 1'b0);
        checkOutput("wr0");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("rd0_%0d", i));
            chk($sformatf("slice%0d", i), q, 128'(i + 1));
        end

        $display("[TB] fill to full and overflow");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, make_word(i), 1'b0);
            checkOutput($sformatf("fill_%0d", i));
        end

        $display("[TB] free one word then refill across wrap");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("free_%0d", i));
        end
        applyStimulus(1'b1, make_word(20), 1'b0);
        checkOutput("refill");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("drain_%0d", i));
        end

        $display("[TB] steady state from half full");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, make_word(30 + i), 1'b0);
        end
        checkOutput("half");
        for (int i = 0; i < 24; i++) begin
            applyStimulus((i % 4) == 3, make_word(40 + i), 1'b1);
            checkOutput($sformatf("steady_%0d", i));
        end

        $display("[TB] reset with data stored");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, make_word(60 + i), 1'b0);
        end
        checkOutput("pre_reset");
        doReset();
        checkOutput("mid_reset");

        $display("[TB] show-ahead instance");
        chk("sa.reset_q",       128'(sa_q),       128'h0);
        chk("sa.reset_rdempty", 128'(sa_rdempty), 128'h1);
        sa_data  = 64'hBBBB_BBBB_AAAA_AAAA;
        sa_wrreq = 1'b1;
        tick();
        sa_wrreq = 1'b0;
        chk("sa.q_head",   128'(sa_q),       128'hAAAA_AAAA);
        chk("sa.rdempty",  128'(sa_rdempty), 128'h0);
        chk("sa.rdusedw",  128'(sa_rdusedw), 128'd2);
        chk("sa.wrusedw",  128'(sa_wrusedw), 128'd1);
        tick();
        chk("sa.q_hold",   128'(sa_q),       128'hAAAA_AAAA);
        sa_rdreq = 1'b1;
        tick();
        sa_rdreq = 1'b0;
        chk("sa.q_next",   128'(sa_q),       128'hBBBB_BBBB);
        chk("sa.rdusedw1", 128'(sa_rdusedw), 128'd1);
        chk("sa.wrusedw1", 128'(sa_wrusedw), 128'd1);
        sa_rdreq = 1'b1;
        tick();
        sa_rdreq = 1'b0;
        chk("sa.empty",    128'(sa_rdempty), 128'h1);
        chk("sa.wrusedw0", 128'(sa_wrusedw), 128'd0);
        chk("sa.underflow",128'(sa_underflow), 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_kband_out_sc.md
Name: fifo_kband_out_sc

Overview:
- Single-clock, parametrised width-down-converting FIFO for the K-band output path.
- Accepts wide systolic-array result words (IN_WIDTH) and returns narrow slices (IN_WIDTH/RATIO) toward the host/DMA interface.
- Generalises the fixed 512->128, depth-8 output FIFO:
  - configurable width, ratio and depth;
  - selectable show-ahead or normal read mode;
  - programmable almost-full threshold;
  - sticky overflow/underflow error flags.

Parameters:
- IN_WIDTH, 512, write word width in bits; must be a multiple of RATIO.
- RATIO, 4, output slices per input word; power of two, 1..16.
- DEPTH, 8, capacity in input words; power of two, >=2.
- AF_THRESH, 6, almost_full asserts when wrusedw >= AF_THRESH; 1..DEPTH.
- SHOW_AHEAD, 0, 1 = q presents head slice whenever !rdempty; 0 = q updates the cycle after an accepted rdreq.

Ports:
- clk, input, 1, single clock for all logic.
- reset, input, 1, synchronous active-high reset; clears contents, pointers and flags.
- data, input, IN_WIDTH, write word.
- wrreq, input, 1, write request.
- rdreq, input, 1, read request (one slice per cycle).
- q, output, IN_WIDTH/RATIO, read slice.
- wrusedw, output, clog2(DEPTH+1), input words occupied; a partially read word counts as occupied.
- rdusedw, output, clog2(DEPTH*RATIO+1), slices remaining.
- rdempty, output, 1, no slices available.
- wrfull, output, 1, wrusedw == DEPTH.
- almost_full, output, 1, wrusedw >= AF_THRESH.
- overflow, output, 1, sticky: a write was attempted while full.
- underflow, output, 1, sticky: a read was attempted while empty.

Behaviour:
- Reset (synchronous, takes priority over everything in the same cycle):
  - wrusedw=0, rdusedw=0, rdempty=1, wrfull=0, almost_full=0, overflow=0, underflow=0, q=0.
  - Reset mid-operation discards all stored data; wrreq/rdreq in the reset cycle are ignored.
- Storage:
  - DEPTH x IN_WIDTH array, write pointer and read word pointer each modulo DEPTH (wrap-around).
  - Slice counter 0..RATIO-1.
- Slice order: least-significant slice first, i.e. slice k = data[(k+1)*W-1 : k*W] with W = IN_WIDTH/RATIO.
- Write:
  - Accepted iff wrreq && !wrfull, evaluated on the registered wrfull.
  - wrreq while wrfull: data dropped, overflow set, state unchanged.
- Read:
  - Accepted iff rdreq && !rdempty, evaluated on the registered rdempty.
  - Each accepted read advances the slice counter.
  - On slice RATIO-1 the counter returns to 0, the read word pointer increments and the word is freed.
  - rdreq while rdempty: ignored, underflow set.
- Latency:
  - Written word becomes readable the cycle after the write (rdempty deasserts at edge+1).
  - A freed word can be rewritten the cycle after its last slice is read; there is no same-cycle full-bypass.
- Simultaneous write and read accepted:
  - rdusedw changes by +RATIO-1.
  - wrusedw is unchanged unless the read frees a word; in that case wrusedw is net 0 (+1-1).
- Counters:
  - Registered and exact after every edge; rdusedw = wrusedw*RATIO - slice counter.
  - wrfull, rdempty and almost_full are registered and consistent with the counters in the same cycle.
- SHOW_AHEAD=1:
  - q is combinationally driven from the head slice; valid whenever rdempty=0.
  - Advances the cycle after an accepted read.
- SHOW_AHEAD=0:
  - q is registered, loaded with the head slice on an accepted read, valid from the next cycle.
  - q holds its value otherwise, including while empty.
- Error flags: overflow and underflow clear only on reset.

Test Plan:
- Reset, then write 0x...0004_0003_0002_0001 (slices 1,2,3,4 at 128-bit boundaries) with SHOW_AHEAD=0 and rdreq held 4 cycles -> q = 1,2,3,4 on successive cycles; rdusedw 4->0; rdempty=1 after the last read.
- Write 8 words back-to-back with no reads -> wrusedw counts 1..8; almost_full rises at count 6; wrfull at 8. A 9th wrreq -> overflow=1, wrusedw stays 8, word 9 not stored.
- Fill to 8, read 4 slices, write one word in the cycle after the 4th slice -> accepted; wrusedw=8. Read all 32 slices -> data in order across pointer wrap.
- Steady state: wrreq every 4th cycle, rdreq every cycle, from half-full -> wrusedw and rdusedw stable (period-4 pattern); no overflow or underflow.
- rdreq on empty FIFO after reset -> underflow=1, q unchanged, rdusedw=0. Assert reset with 3 words stored -> all counters 0 and flags clear next cycle.
- SHOW_AHEAD=1, RATIO=2, IN_WIDTH=64: write 0xBBBB_BBBB_AAAA_AAAA -> next cycle q=0xAAAAAAAA with no rdreq; one rdreq -> q=0xBBBBBBBB.
